// File: rtl/cla_pkg.sv
// Shared widths and group generate/propagate helpers for the CLA adder/subtractor family.
package cla_pkg;

  localparam int CLA_WIDTH     = 64;
  localparam int CLA_GROUP     = 4;
  localparam int CLA_HALF      = CLA_WIDTH / 2;
  localparam int CLA_MAX_GROUP = 8;

  // Groups narrower than CLA_MAX_GROUP are padded with g=0/p=1, which leaves both results unchanged.
  function automatic logic grp_generate(input logic [CLA_MAX_GROUP-1:0] g,
                                        input logic [CLA_MAX_GROUP-1:0] p);
    logic r;
    r = 1'b0;
    for (int i = 0; i < CLA_MAX_GROUP; i++) r = g[i] | (p[i] & r);
    return r;
  endfunction

  function automatic logic grp_propagate(input logic [CLA_MAX_GROUP-1:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/cla_half.sv
// Combinational two-level carry-lookahead adder: G-bit groups, then lookahead across groups.
module cla_half
  import cla_pkg::*;
#(
  parameter int W = CLA_HALF,
  parameter int G = CLA_GROUP
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / G;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic [CLA_MAX_GROUP-1:0] gv;
    logic [CLA_MAX_GROUP-1:0] pv;
    gg = '0;
    gp = '0;
    gv = '0;
    pv = '1;
    for (int k = 0; k < NG; k++) begin
      gv = '0;
      pv = '1;
      gv[G-1:0] = g[k*G +: G];
      pv[G-1:0] = p[k*G +: G];
      gg[k] = grp_generate(gv, pv);
      gp[k] = grp_propagate(pv);
    end
  end

  // Group carries come from the second level; bit carries are only resolved inside each group.
  always_comb begin
    logic gcarry;
    logic bcarry;
    gcarry = cin;
    bcarry = 1'b0;
    c      = '0;
    for (int k = 0; k < NG; k++) begin
      bcarry = gcarry;
      for (int i = 0; i < G; i++) begin
        c[k*G+i] = bcarry;
        bcarry   = g[k*G+i] | (p[k*G+i] & bcarry);
      end
      gcarry = gg[k] | (gp[k] & gcarry);
    end
    cout = gcarry;
  end

  assign sum = p ^ c;

endmodule

// File: rtl/cla_sub_64_pipe.sv
// Two-stage pipelined subtractor (op1 + ~op2 + 1): low half in stage 1, high half in stage 2.
module cla_sub_64_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             brout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] op2_n;
  logic             s1_valid;
  logic [H-1:0]     s1_lo;
  logic             s1_c;
  logic [H-1:0]     s1_a_hi;
  logic [H-1:0]     s1_b_hi;
  logic             s1_sa;
  logic             s1_sb;
  logic [H-1:0]     lo_sum;
  logic             lo_cout;
  logic [H-1:0]     hi_sum;
  logic             hi_cout;
  logic             adv2;
  logic             in_xfer;

  assign op2_n    = ~op2;
  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign in_xfer  = in_valid && in_ready;

  cla_half #(.W(H), .G(GROUP)) u_lo (
    .a    (op1[H-1:0]),
    .b    (op2_n[H-1:0]),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_half #(.W(H), .G(GROUP)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .cin  (s1_c),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // s1_sb keeps op2's original sign; the registered upper half of op2 is already inverted.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_c      <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_sa     <= 1'b0;
      s1_sb     <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      brout     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_lo    <= lo_sum;
        s1_c     <= lo_cout;
        s1_a_hi  <= op1[WIDTH-1:H];
        s1_b_hi  <= op2_n[WIDTH-1:H];
        s1_sa    <= op1[WIDTH-1];
        s1_sb    <= op2[WIDTH-1];
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        out_valid <= 1'b1;
        diff      <= {hi_sum, s1_lo};
        brout     <= ~hi_cout;
        ovf       <= (s1_sa != s1_sb) && (hi_sum[H-1] != s1_sa);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_64_pipe.sv
// Bench for cla_sub_64_pipe: directed vector table, backpressure/reset sequences, random scoreboard run.
module tb_cla_sub_64_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] diff;
  logic        brout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        br;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        br;
    logic        ov;
    int          cyc;
    bit          strict;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  exp_t        sbq[$];
  exp_t        e;
  vec_t        vecs[8];
  logic [63:0] pend_d;
  logic        pend_br;
  logic        pend_ov;
  bit          stream_phase = 1'b0;
  bit          rand_phase = 1'b0;

  cla_sub_64_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .op1       (op1),
    .op2       (op2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .brout     (brout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain modular, unsigned and wide signed arithmetic.
  function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] d, output logic br, output logic ov);
    logic signed [64:0] s;
    d  = a - b;
    br = (a < b);
    s  = $signed({a[63], a}) - $signed({b[63], b});
    ov = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] d, input logic br, input logic ov);
    bit accepted;
    accepted = 1'b0;
    op1      = a;
    op2      = b;
    pend_d   = d;
    pend_br  = br;
    pend_ov  = ov;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance within 60 cycles");
    end
  endtask

  task automatic end_stream();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clock);
      #1;
    end
    checkOutput("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  // Scoreboard: record accepted operands and check each consumed result in order.
  always @(negedge clock) begin
    if (reset) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got diff=%h expected no result", diff);
        end else begin
          e = sbq.pop_front();
          checkOutput("diff", diff, e.d);
          checkOutput("brout", 64'(brout), 64'(e.br));
          checkOutput("ovf", 64'(ovf), 64'(e.ov));
          if (e.strict) checkOutput("latency", 64'(cycle - e.cyc), 64'd2);
        end
      end
      if (in_valid && in_ready)
        sbq.push_back('{d: pend_d, br: pend_br, ov: pend_ov, cyc: cycle, strict: stream_phase});
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_phase) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [63:0] a, b, d;
    logic        br, ov;

    vecs[0] = '{64'hf20f_ffff_ffff_ffff, 64'hffff_ffff_ffff_ff50, 64'hf210_0000_0000_00af, 1'b1, 1'b0};
    vecs[1] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0};
    vecs[2] = '{64'd0, 64'd1, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_ffff_ffff, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7fff_ffff_ffff_ffff, 1'b0, 1'b1};
    vecs[5] = '{64'h7fff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0, 64'd0, 1'b0, 1'b0};
    vecs[7] = '{64'd0, 64'd0, 64'd0, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b1;
    op1       = 64'h0123_4567_89ab_cdef;
    op2       = 64'h0000_0000_0000_0042;
    out_ready = 1'b1;
    pend_d    = '0;
    pend_br   = 1'b0;
    pend_ov   = 1'b0;

    $display("[TB] reset and idle");
    repeat (2) begin
      @(negedge clock);
      if (cycle > 0) begin
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_diff", diff, 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      end
    end
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clock);
    #1;

    $display("[TB] directed vector table");
    stream_phase = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov);
    end_stream();
    drain();

    $display("[TB] backpressure");
    stream_phase = 1'b0;
    out_ready    = 1'b0;
    a = 64'h0000_0000_0000_0100;
    b = 64'h0000_0000_0000_0001;
    ref_model(a, b, d, br, ov);
    applyStimulus(a, b, d, br, ov);
    ref_model(64'hdead_beef_0000_0000, 64'h0000_0001_0000_0001, d, br, ov);
    applyStimulus(64'hdead_beef_0000_0000, 64'h0000_0001_0000_0001, d, br, ov);
    ref_model(64'd7, 64'd9, d, br, ov);
    op1      = 64'd7;
    op2      = 64'd9;
    pend_d   = d;
    pend_br  = br;
    pend_ov  = ov;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_diff_hold", diff, 64'h0000_0000_0000_00ff);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(64'd7, 64'd9, d, br, ov);
    ref_model(64'h8000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff, d, br, ov);
    applyStimulus(64'h8000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff, d, br, ov);
    end_stream();
    drain();

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    ref_model(64'd100, 64'd1, d, br, ov);
    applyStimulus(64'd100, 64'd1, d, br, ov);
    ref_model(64'd200, 64'd2, d, br, ov);
    applyStimulus(64'd200, 64'd2, d, br, ov);
    end_stream();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("flush_no_ghost", 64'(out_valid), 64'd0);
    end
    @(posedge clock);
    #1;
    stream_phase = 1'b1;
    applyStimulus(64'h0000_0002_0000_0000, 64'h0000_0000_0000_0003, 64'h0000_0001_ffff_fffd, 1'b0, 1'b0);
    end_stream();
    drain();

    $display("[TB] random run");
    stream_phase = 1'b0;
    rand_phase   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 64'h8000_0000_0000_0000;
        2: b = 64'hffff_ffff_ffff_ffff;
        3: begin a[31:0] = '0; b[31:0] = 32'd1; end
        default: ;
      endcase
      ref_model(a, b, d, br, ov);
      applyStimulus(a, b, d, br, ov);
      if ($urandom_range(0, 5) == 0) begin
        end_stream();
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    end_stream();
    rand_phase = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("final_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
